shared_var_arbiter: RTL and testbench
=====================================

SHARED_VAR_ARBITER -- requirements
Module: shared_var_arbiter

Interface
REQ-001 SHALL have parameter N_CH, 4: number of writer channels, legal 2..8.
REQ-002 SHALL have parameter WIDTH, 8: width of the shared variable, legal 1..32.
REQ-003 SHALL have parameter RST_VAL, 0: reset value of var_q (WIDTH bits).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_req  input  N_CH  per-channel write request; held until granted.
REQ-007 SHALL have port wr_op  input  2*N_CH  per-channel op, channel i at [2i+1:2i]: 00 load, 01 AND, 10 OR, 11 XOR.
REQ-008 SHALL have port wr_data  input  WIDTH*N_CH  per-channel operand, channel i at [WIDTH*i +: WIDTH].
REQ-009 SHALL have port wr_lock  input  N_CH  per-channel request to keep ownership after grant.
REQ-010 SHALL have port wr_gnt  output  N_CH  one-hot grant, combinational from wr_req, state and pointer.
REQ-011 SHALL have port var_q  output  WIDTH  registered shared variable.
REQ-012 SHALL have port upd  output  1  registered pulse, high the cycle after var_q changed by a grant.
REQ-013 SHALL have port conflict_cnt  output  16  count of cycles with more than one request (macro-dependent).

Function
REQ-014 SHALL assert at most one wr_gnt bit per cycle; wr_gnt SHALL be 0 when wr_req is 0.
REQ-015 SHALL update var_q on the edge where wr_gnt[i]&wr_req[i]: load -> wr_data_i; AND/OR/XOR -> var_q op wr_data_i, bitwise, WIDTH bits, no carry.
REQ-016 SHALL make the update visible on var_q one cycle after the grant (latency 1); upd SHALL pulse in that same cycle.
REQ-017 SHALL implement a 2-state FSM: IDLE and LOCKED, with owner register holding the locked channel index.
REQ-018 SHALL in IDLE grant round-robin: search starts at pointer rr, first requesting channel wins, rr <= winner+1 modulo N_CH.
REQ-019 SHALL go IDLE -> LOCKED when the granted channel has wr_lock=1, latching owner=winner.
REQ-020 SHALL in LOCKED grant only owner; other requests SHALL wait, never dropped or reordered.
REQ-021 SHALL go LOCKED -> IDLE on the edge where owner has wr_lock=0, whether or not it also requests; a write from owner in that cycle SHALL still be applied.
REQ-022 SHALL wrap rr from N_CH-1 to 0.
REQ-023 SHALL count, in conflict_cnt, each cycle with two or more wr_req bits set, in either state, saturating at 16'hFFFF.
REQ-024 SHALL ignore wr_op/wr_data/wr_lock of non-granted channels.

Reset
REQ-025 SHALL on rst_n=0, immediately and independent of clk: var_q=RST_VAL, upd=0, conflict_cnt=0, state=IDLE, owner=0, rr=0.
REQ-026 SHALL hold wr_gnt=0 while rst_n=0.
REQ-027 SHALL abandon an in-flight grant or lock on reset; no partial update of var_q.
REQ-028 SHALL resume arbitration at the first rising edge after rst_n deasserts with channel 0 at highest priority.

Configuration
REQ-029 SHALL use macro SHARED_VAR_CONFLICT_CNT_EN.
REQ-030 SHALL with the macro defined implement conflict_cnt per REQ-023.
REQ-031 SHALL without the macro tie conflict_cnt to 0 and synthesise no counter; all other behaviour identical.

Verification (N_CH=4, WIDTH=8, RST_VAL=0, macro defined)
REQ-032 SHALL check reset: rst_n=0 mid-cycle while ch1 locked -> var_q=8'h00, wr_gnt=0, conflict_cnt=0 without a clock edge.
REQ-033 SHALL check ops: ch0 load 8'hF0, then ch0 OR 8'h0F, AND 8'h3C, XOR 8'hFF -> var_q 8'hF0, 8'hFF, 8'h3C, 8'hC3, each one cycle after grant, upd pulsing each.
REQ-034 SHALL check round-robin: wr_req=4'b1111 held 5 cycles -> grants ch0,ch1,ch2,ch3,ch0; conflict_cnt=5.
REQ-035 SHALL check lock: ch2 load 8'hAA with wr_lock=1, ch1 requesting -> ch2 granted 3 cycles while lock held, ch1 granted the cycle after ch2 drops lock.
REQ-036 SHALL check saturation: force 65540 conflict cycles -> conflict_cnt stays 16'hFFFF.
REQ-037 SHALL check macro off: same as REQ-034 -> identical grants, conflict_cnt=0.

Source files
------------

// File: rtl/shared_var_arbiter.sv
// shared_var_arbiter: N_CH writers share one WIDTH-bit variable.
// Writers are arbitrated round-robin. A granted writer may hold the lock
// so that only it is served until it drops wr_lock. Each granted write
// loads var_q or combines it bitwise with the operand (AND/OR/XOR).
// The change shows on var_q one cycle after the grant, with a one-cycle
// upd pulse at the same time.
// Optional feature macro: SHARED_VAR_CONFLICT_CNT_EN. When it is defined,
// conflict_cnt is a saturating count of cycles with two or more requests.
// When it is undefined, conflict_cnt is tied to zero.
module shared_var_arbiter #(
    parameter int                N_CH    = 4,
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         wr_req,
    input  logic [2*N_CH-1:0]       wr_op,
    input  logic [WIDTH*N_CH-1:0]   wr_data,
    input  logic [N_CH-1:0]         wr_lock,
    output logic [N_CH-1:0]         wr_gnt,
    output logic [WIDTH-1:0]        var_q,
    output logic                    upd,
    output logic [15:0]             conflict_cnt
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [PTR_W-1:0]   rr_reg, rr_next;
    logic [WIDTH-1:0]   var_reg, var_next;
    logic               upd_reg;

    logic [1:0]         ch_op   [N_CH];
    logic [WIDTH-1:0]   ch_data [N_CH];

    logic               rr_win_valid;
    logic [PTR_W-1:0]   rr_win_idx;
    logic [PTR_W-1:0]   cand;
    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;

    // Split the flat per-channel buses into indexable arrays and build the one-hot grant
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign ch_op[gi]   = wr_op[2*gi +: 2];
            assign ch_data[gi] = wr_data[WIDTH*gi +: WIDTH];
            assign wr_gnt[gi]  = gnt_valid && (gnt_idx == PTR_W'(gi));
        end
    endgenerate

    // Round-robin search: first requesting channel at or after the pointer, wrapping
    always_comb begin
        rr_win_valid = 1'b0;
        rr_win_idx   = '0;
        cand         = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = PTR_W'((int'(rr_reg) + k) % N_CH);
            if (!rr_win_valid && wr_req[cand]) begin
                rr_win_valid = 1'b1;
                rr_win_idx   = cand;
            end
        end
    end

    // FSM state register together with the owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            rr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
        end
    end

    // FSM next state: enter the lock on a locking grant, leave it when the owner drops wr_lock
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (gnt_valid) begin
                    rr_next = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    if (wr_lock[gnt_idx]) begin
                        state_next = ST_LOCKED;
                        owner_next = gnt_idx;
                    end
                end
            end
            ST_LOCKED: begin
                // The owner's lock bit counts even in a cycle where it is not requesting
                if (!wr_lock[owner_reg]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: pick the grant, which the lock restricts to the owner; nothing is granted in reset
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        case (state_reg)
            ST_IDLE: begin
                gnt_valid = rr_win_valid;
                gnt_idx   = rr_win_idx;
            end
            ST_LOCKED: begin
                gnt_valid = wr_req[owner_reg];
                gnt_idx   = owner_reg;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = '0;
            end
        endcase
        if (!rst_n) begin
            gnt_valid = 1'b0;
        end
    end

    // Apply the granted channel's operation to the current value
    always_comb begin
        var_next = var_reg;
        case (ch_op[gnt_idx])
            2'b00:   var_next = ch_data[gnt_idx];
            2'b01:   var_next = var_reg & ch_data[gnt_idx];
            2'b10:   var_next = var_reg | ch_data[gnt_idx];
            default: var_next = var_reg ^ ch_data[gnt_idx];
        endcase
    end

    // Shared variable and update pulse; only a grant changes the value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            var_reg <= RST_VAL;
            upd_reg <= 1'b0;
        end else begin
            upd_reg <= gnt_valid;
            if (gnt_valid) begin
                var_reg <= var_next;
            end
        end
    end

    assign var_q = var_reg;
    assign upd   = upd_reg;

`ifdef SHARED_VAR_CONFLICT_CNT_EN
    logic [15:0] cnt_reg;
    logic        multi_req;

    // Two or more bits are set exactly when clearing the lowest set bit leaves something behind
    assign multi_req = |(wr_req & (wr_req - N_CH'(1)));

    // Saturating count of contended cycles, in either FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (multi_req && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign conflict_cnt = cnt_reg;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_shared_var_arbiter.sv
// Testbench for shared_var_arbiter (N_CH=4, WIDTH=8, RST_VAL=0).
// The expected conflict count follows SHARED_VAR_CONFLICT_CNT_EN, so the
// same bench works whether or not the macro is defined.
module tb_shared_var_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wr_req;
    logic [7:0]  wr_op;
    logic [31:0] wr_data;
    logic [3:0]  wr_lock;
    logic [3:0]  wr_gnt;
    logic [7:0]  var_q;
    logic        upd;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers
    int m_var, m_rr, m_locked, m_owner, m_cnt, m_upd;
`ifdef SHARED_VAR_CONFLICT_CNT_EN
    bit cnt_en = 1'b1;
`else
    bit cnt_en = 1'b0;
`endif

    logic [3:0] g;
    logic [3:0] gnt_seq [5];

    shared_var_arbiter #(
        .N_CH    (4),
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .wr_op        (wr_op),
        .wr_data      (wr_data),
        .wr_lock      (wr_lock),
        .wr_gnt       (wr_gnt),
        .var_q        (var_q),
        .upd          (upd),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_var = 0; m_rr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; m_upd = 0;
    endtask

    task automatic clear_inputs();
        wr_req = '0; wr_op = '0; wr_data = '0; wr_lock = '0;
    endtask

    task automatic set_ch(input int ch, input logic r, input logic [1:0] op,
                          input logic [7:0] d, input logic lk);
        wr_req[ch]         = r;
        wr_op[2*ch +: 2]   = op;
        wr_data[8*ch +: 8] = d;
        wr_lock[ch]        = lk;
    endtask

    // Who should win: the lock owner if it asks, else first requester from the pointer on
    function automatic int model_grant();
        if (m_locked != 0) return wr_req[m_owner] ? m_owner : -1;
        for (int k = 0; k < 4; k++) begin
            if (wr_req[(m_rr + k) % 4]) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: check the grant, advance the model, then check the registered outputs
    task automatic cycle(output logic [3:0] gout);
        int w;
        int d;
        logic [31:0] exp_gnt;
        #1;
        w = model_grant();
        exp_gnt = (w < 0) ? 32'h0 : (32'h1 << w);
        gout = wr_gnt;
        check("gnt", 32'(wr_gnt), exp_gnt);
        if (cnt_en && $countones(wr_req) >= 2 && m_cnt < 65535) m_cnt++;
        m_upd = (w >= 0) ? 1 : 0;
        if (w >= 0) begin
            d = int'(wr_data[8*w +: 8]);
            case (wr_op[2*w +: 2])
                2'b00:   m_var = d;
                2'b01:   m_var = m_var & d;
                2'b10:   m_var = m_var | d;
                default: m_var = m_var ^ d;
            endcase
        end
        if (m_locked == 0) begin
            if (w >= 0) begin
                m_rr = (w + 1) % 4;
                if (wr_lock[w]) begin
                    m_locked = 1;
                    m_owner  = w;
                end
            end
        end else if (!wr_lock[m_owner]) begin
            m_locked = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("var_q", 32'(var_q), 32'(m_var));
        check("upd", 32'(upd), 32'(m_upd));
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    endtask

    initial begin
        // Reset state, with every request raised to show the grant is gated
        rst_n = 1'b0;
        wr_req = 4'b1111; wr_op = '0; wr_data = 32'h44332211; wr_lock = 4'b1111;
        model_reset();
        #3;
        check("rst_var", 32'(var_q), 32'h00);
        check("rst_upd", 32'(upd), 32'h0);
        check("rst_cnt", 32'(conflict_cnt), 32'h0);
        check("rst_gnt", 32'(wr_gnt), 32'h0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Operations on channel 0
        set_ch(0, 1'b1, 2'b00, 8'hF0, 1'b0); cycle(g);
        check("op_load_gnt", 32'(g), 32'h1);
        check("op_load_var", 32'(var_q), 32'hF0);
        check("op_load_upd", 32'(upd), 32'h1);
        set_ch(0, 1'b1, 2'b10, 8'h0F, 1'b0); cycle(g);
        check("op_or_var", 32'(var_q), 32'hFF);
        check("op_or_upd", 32'(upd), 32'h1);
        set_ch(0, 1'b1, 2'b01, 8'h3C, 1'b0); cycle(g);
        check("op_and_var", 32'(var_q), 32'h3C);
        set_ch(0, 1'b1, 2'b11, 8'hFF, 1'b0); cycle(g);
        check("op_xor_var", 32'(var_q), 32'hC3);
        check("op_xor_upd", 32'(upd), 32'h1);
        clear_inputs(); cycle(g);
        check("idle_upd", 32'(upd), 32'h0);
        check("idle_var", 32'(var_q), 32'hC3);

        // Channel 1 locks, then reset lands mid-cycle with a write pending
        set_ch(0, 1'b1, 2'b00, 8'h11, 1'b0);
        set_ch(1, 1'b1, 2'b00, 8'h55, 1'b1);
        cycle(g);
        check("lock1_gnt", 32'(g), 32'h2);
        check("lock1_var", 32'(var_q), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_var", 32'(var_q), 32'h00);
        check("midrst_gnt", 32'(wr_gnt), 32'h0);
        check("midrst_cnt", 32'(conflict_cnt), 32'h0);
        check("midrst_upd", 32'(upd), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_hold_var", 32'(var_q), 32'h00);
        clear_inputs();
        rst_n = 1'b1;

        // Round-robin with all four channels requesting
        gnt_seq[0] = 4'b0001; gnt_seq[1] = 4'b0010; gnt_seq[2] = 4'b0100;
        gnt_seq[3] = 4'b1000; gnt_seq[4] = 4'b0001;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 2'b00, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(g);
            check($sformatf("rr_gnt%0d", i), 32'(g), 32'(gnt_seq[i]));
        end
        check("rr_cnt", 32'(conflict_cnt), cnt_en ? 32'd5 : 32'd0);

        // Lock hold: ch2 locks, ch1 waits until the lock is released
        clear_inputs();
        set_ch(2, 1'b1, 2'b00, 8'hAA, 1'b1); cycle(g);
        check("lk_gnt0", 32'(g), 32'h4);
        check("lk_var0", 32'(var_q), 32'hAA);
        set_ch(1, 1'b1, 2'b00, 8'h11, 1'b0);
        cycle(g); check("lk_gnt1", 32'(g), 32'h4);
        cycle(g); check("lk_gnt2", 32'(g), 32'h4);
        check("lk_var2", 32'(var_q), 32'hAA);
        set_ch(2, 1'b0, 2'b00, 8'hAA, 1'b0);
        cycle(g); check("lk_release_gnt", 32'(g), 32'h0);
        cycle(g); check("lk_after_gnt", 32'(g), 32'h2);
        check("lk_after_var", 32'(var_q), 32'h11);

        // Random traffic: requests are held until granted
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (!wr_req[ch] && $urandom_range(0, 99) < 40)
                    set_ch(ch, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
                wr_lock[ch] = ($urandom_range(0, 99) < 35);
            end
            cycle(g);
            wr_req = wr_req & ~g;
        end

        // Saturation of the conflict counter
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        wr_req = 4'b1111;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_fffe", 32'(conflict_cnt), cnt_en ? 32'hFFFE : 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("sat_ffff", 32'(conflict_cnt), cnt_en ? 32'hFFFF : 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sat_hold", 32'(conflict_cnt), cnt_en ? 32'hFFFF : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
